// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the pipelined adder:
//   - default values for WIDTH, STAGES and CNT_W
//   - stage_payload_t: the {sum, cout, ovf} record carried by every stage,
//     sized for the default width (adder_pipe derives a width-matched copy)
//   - signed_ovf(): two's-complement overflow from the three sign bits
// -----------------------------------------------------------------------------
package adder_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_STAGES = 2;
    localparam int DEF_CNT_W  = 16;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] sum;
        logic                 cout;
        logic                 ovf;
    } stage_payload_t;

    // Overflow happens only when both operands share a sign and the result does not.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// -----------------------------------------------------------------------------
// adder_pipe_stage
// One pipeline slot: a valid bit plus a payload register and its load rule.
// The slot loads when it is empty or when its contents move downstream in
// the same cycle (down_load).
// Ports:
//   clk, rstn      clock, asynchronous active-low reset
//   up_valid, d    valid bit and payload offered by the upstream side
//   down_load      downstream takes this slot's contents this cycle
//   load           this slot loads this cycle (upstream may transfer)
//   valid, q       registered valid bit and payload
// -----------------------------------------------------------------------------
module adder_pipe_stage
    import adder_pkg::*;
#(
    parameter type payload_t = stage_payload_t
) (
    input  logic     clk,
    input  logic     rstn,
    input  logic     up_valid,
    input  payload_t d,
    input  logic     down_load,
    output logic     load,
    output logic     valid,
    output payload_t q
);

    logic     valid_r;
    payload_t q_r;

    assign load  = ~valid_r | down_load;
    assign valid = valid_r;
    assign q     = q_r;

    // Slot register: capture upstream on load; payload only changes when real data arrives.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_r <= 1'b0;
            q_r     <= '0;
        end else if (load) begin
            valid_r <= up_valid;
            if (up_valid) begin
                q_r <= d;
            end else begin
                q_r <= q_r;
            end
        end else begin
            valid_r <= valid_r;
            q_r     <= q_r;
        end
    end

endmodule

// File: rtl/adder_pipe.sv
// -----------------------------------------------------------------------------
// adder_pipe
// Valid/ready pipelined adder: {cout,sum} = a + b + cin, with signed
// overflow flag, STAGES register slots and a count of output transfers.
// The addition happens in front of slot 0; later slots only carry the result.
// Optional build macro: ADDER_PIPE_SAT_EN -- clamp sum to the signed limits
// on overflow (ovf and cout still describe the unclamped result).
// Ports:
//   clk, rstn             clock, asynchronous active-low reset
//   in_valid, in_ready    input handshake (in_ready is independent of in_valid)
//   a, b, cin             operands and carry in
//   out_valid, out_ready  output handshake
//   sum, cout, ovf        registered result
//   count                 completed output transfers, wraps at 2^CNT_W
// -----------------------------------------------------------------------------
module adder_pipe
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [CNT_W-1:0] count
);

    // Same layout as stage_payload_t, sized to this instance's WIDTH.
    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } payload_t;

    logic [WIDTH:0]   full_s;
    payload_t         add_s;
    logic [CNT_W-1:0] count_r;

    // Stage-0 arithmetic: full-width sum, flags and optional saturation.
    always_comb begin
        full_s     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        add_s      = '0;
        add_s.cout = full_s[WIDTH];
        add_s.ovf  = signed_ovf(a[WIDTH-1], b[WIDTH-1], full_s[WIDTH-1]);
`ifdef ADDER_PIPE_SAT_EN
        if (add_s.ovf) begin
            // Operands share a sign on overflow, so a's MSB picks the limit.
            if (a[WIDTH-1]) begin
                add_s.sum = {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
                add_s.sum = {1'b0, {(WIDTH-1){1'b1}}};
            end
        end else begin
            add_s.sum = full_s[WIDTH-1:0];
        end
`else
        add_s.sum = full_s[WIDTH-1:0];
`endif
    end

    // Slot chain: each slot's load depends on the next one, ending at out_ready,
    // so in_ready ripples back combinationally from the output.
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic     up_valid_s;
        logic     down_load_s;
        logic     load_s;
        logic     valid_s;
        payload_t d_s;
        payload_t q_s;

        if (i == 0) begin : g_first
            assign up_valid_s = in_valid;
            assign d_s        = add_s;
        end else begin : g_follow
            assign up_valid_s = g_stage[i-1].valid_s;
            assign d_s        = g_stage[i-1].q_s;
        end

        // Last slot empties on an output transfer; load = ~valid | out_ready.
        if (i == STAGES - 1) begin : g_last
            assign down_load_s = out_ready;
        end else begin : g_inner
            assign down_load_s = g_stage[i+1].load_s;
        end

        adder_pipe_stage #(
            .payload_t (payload_t)
        ) u_stage (
            .clk       (clk),
            .rstn      (rstn),
            .up_valid  (up_valid_s),
            .d         (d_s),
            .down_load (down_load_s),
            .load      (load_s),
            .valid     (valid_s),
            .q         (q_s)
        );
    end

    assign in_ready  = g_stage[0].load_s;
    assign out_valid = g_stage[STAGES-1].valid_s;
    assign sum       = g_stage[STAGES-1].q_s.sum;
    assign cout      = g_stage[STAGES-1].q_s.cout;
    assign ovf       = g_stage[STAGES-1].q_s.ovf;
    assign count     = count_r;

    // Output transfer counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_r <= '0;
        end else if (out_valid && out_ready) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: tb/tb_adder_pipe.sv
// -----------------------------------------------------------------------------
// tb_adder_pipe
// Directed bench for adder_pipe (WIDTH=8, STAGES=2, CNT_W=16): reset state,
// arithmetic vectors with latency, backpressure ordering/hold, reset while
// busy, and counter wrap. Expectations follow ADDER_PIPE_SAT_EN if defined.
// -----------------------------------------------------------------------------
module tb_adder_pipe;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  sum;
    logic        cout;
    logic        ovf;
    logic [15:0] count;

    int total = 0;
    int bad   = 0;

    logic [7:0] va  [8];
    logic [7:0] vb  [8];
    logic       vc  [8];
    logic [9:0] ve  [8];
    logic [7:0] bpa [4];
    logic [7:0] bpb [4];
    logic       bpc [4];
    logic [9:0] bpe [4];

    always #5 clk = ~clk;

    adder_pipe #(
        .WIDTH  (8),
        .STAGES (2),
        .CNT_W  (16)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .count     (count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    initial begin
        int acc;
        int oidx;
        int n_in;
        int n_out;
        int seq_err;
        logic seen;
        logic mid_done;

        // {sum, cout, ovf}
        va[0] = 8'h0F; vb[0] = 8'h01; vc[0] = 1'b0; ve[0] = {8'h10, 1'b0, 1'b0};
        va[1] = 8'hFF; vb[1] = 8'h01; vc[1] = 1'b0; ve[1] = {8'h00, 1'b1, 1'b0};
        va[3] = 8'h80; vb[3] = 8'h80; vc[3] = 1'b0;
        va[2] = 8'h7F; vb[2] = 8'h01; vc[2] = 1'b0;
        va[4] = 8'h80; vb[4] = 8'hFF; vc[4] = 1'b0;
        va[5] = 8'h55; vb[5] = 8'hAA; vc[5] = 1'b1; ve[5] = {8'h00, 1'b1, 1'b0};
        va[6] = 8'h12; vb[6] = 8'h34; vc[6] = 1'b1; ve[6] = {8'h47, 1'b0, 1'b0};
        va[7] = 8'hFF; vb[7] = 8'hFF; vc[7] = 1'b1; ve[7] = {8'hFF, 1'b1, 1'b0};
        bpa[0] = 8'h01; bpb[0] = 8'h02; bpc[0] = 1'b0; bpe[0] = {8'h03, 1'b0, 1'b0};
        bpa[1] = 8'h10; bpb[1] = 8'h20; bpc[1] = 1'b1; bpe[1] = {8'h31, 1'b0, 1'b0};
        bpa[2] = 8'hF0; bpb[2] = 8'h20; bpc[2] = 1'b0; bpe[2] = {8'h10, 1'b1, 1'b0};
        bpa[3] = 8'h40; bpb[3] = 8'h40; bpc[3] = 1'b0;
`ifdef ADDER_PIPE_SAT_EN
        ve[2]  = {8'h7F, 1'b0, 1'b1};
        ve[3]  = {8'h80, 1'b1, 1'b1};
        ve[4]  = {8'h80, 1'b1, 1'b1};
        bpe[3] = {8'h7F, 1'b0, 1'b1};
`else
        ve[2]  = {8'h80, 1'b0, 1'b1};
        ve[3]  = {8'h00, 1'b1, 1'b1};
        ve[4]  = {8'h7F, 1'b1, 1'b1};
        bpe[3] = {8'h80, 1'b0, 1'b1};
`endif

        // Reset state
        rstn = 1'b0; in_valid = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0; out_ready = 1'b1;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_result", {sum, cout, ovf}, 0);
        @(posedge clk); #1 rstn = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", in_ready, 1);

        // Arithmetic vectors, one at a time, checking 2-cycle latency
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; a = va[k]; b = vb[k]; cin = vc[k];
            @(negedge clk);
            chk("basic_in_ready", in_ready, 1);
            @(posedge clk); #1 in_valid = 1'b0;
            @(negedge clk);
            chk("basic_lat1_valid", out_valid, 0);
            @(negedge clk);
            chk("basic_lat2_valid", out_valid, 1);
            chk("basic_result", {sum, cout, ovf}, ve[k]);
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("basic_drained", out_valid, 0);
        chk("basic_count", count, 8);

        // Backpressure: out_ready low for 5 cycles with 4 inputs offered
        acc = 0; oidx = 0;
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 40 && oidx < 4; cyc++) begin
            out_ready = (cyc >= 5);
            in_valid  = (acc < 4);
            if (acc < 4) begin
                a = bpa[acc]; b = bpb[acc]; cin = bpc[acc];
            end
            @(negedge clk);
            if (cyc == 4) begin
                chk("bp_accepted", acc, 2);
                chk("bp_in_ready_low", in_ready, 0);
            end
            if (out_valid && !out_ready) chk("bp_hold", {sum, cout, ovf}, bpe[oidx]);
            if (out_valid && out_ready) begin
                chk("bp_order", {sum, cout, ovf}, bpe[oidx]);
                oidx++;
            end
            if (in_valid && in_ready) acc++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("bp_all_out", oidx, 4);
        @(negedge clk);
        chk("bp_no_dup", out_valid, 0);
        chk("bp_count", count, 12);

        // Reset with two results in flight
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b0;
        @(posedge clk); #1 a = 8'h33;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_pre_valid", out_valid, 1);
        #1 rstn = 1'b0;
        #1;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_count", count, 0);
        @(posedge clk); #1 rstn = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("rst_mid_in_ready", in_ready, 1);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("rst_mid_no_stale", seen, 0);

        // Counter wrap: 65536 streaming transfers
        n_in = 0; n_out = 0; seq_err = 0; mid_done = 1'b0;
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 70000 && n_out < 65536; cyc++) begin
            in_valid = (n_in < 65536);
            a = n_in[7:0]; b = 8'h00; cin = 1'b0;
            @(negedge clk);
            if (n_out == 65535 && !mid_done) begin
                chk("wrap_ffff", count, 16'hFFFF);
                mid_done = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (sum !== n_out[7:0]) seq_err++;
                n_out++;
            end
            if (in_valid && in_ready) n_in++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("wrap_out_count", n_out, 65536);
        chk("wrap_order", seq_err, 0);
        @(negedge clk);
        chk("wrap_zero", count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
